// File: rtl/debounce_pulse_gen.sv
// Raw button conditioner: synchronizer, debounce FSM, rise/fall pulses and
// optional hold-to-auto-repeat on o_pulse (drives a counter's count enable).
module debounce_pulse_gen #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned REPEAT_EN       = 1,
  parameter int unsigned REPEAT_DELAY    = 500000,
  parameter int unsigned REPEAT_PERIOD   = 100000
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall,
  output logic o_pulse
);

  localparam int unsigned MAX_DR  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int unsigned MAX_CNT = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_RELEASED,
    S_WAIT_PRESS,
    S_PRESSED,
    S_WAIT_RELEASE
  } state_t;

  typedef enum logic {
    PH_DELAY,
    PH_PERIOD
  } phase_t;

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_dcnt;
  logic [CNT_W-1:0]       w_dcnt_nxt;
  logic [CNT_W-1:0]       r_rcnt;
  logic [CNT_W-1:0]       w_rcnt_nxt;
  logic [CNT_W-1:0]       w_rlast;
  phase_t                 r_phase;
  phase_t                 w_phase_nxt;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;
  logic                   r_pulse;
  logic                   w_level_nxt;
  logic                   w_rise_nxt;
  logic                   w_fall_nxt;
  logic                   w_pulse_nxt;
  logic                   w_s;

  // Metastability chain; only the last stage is used downstream
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_sync <= '0;
    else            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
  end

  assign w_s     = r_sync[SYNC_STAGES-1];
  assign w_rlast = (r_phase == PH_PERIOD) ? PER_LAST : DLY_LAST;

  // State, counters and registered outputs
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_RELEASED;
      r_dcnt  <= '0;
      r_rcnt  <= '0;
      r_phase <= PH_DELAY;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dcnt  <= w_dcnt_nxt;
      r_rcnt  <= w_rcnt_nxt;
      r_phase <= w_phase_nxt;
      r_level <= w_level_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
      r_pulse <= w_pulse_nxt;
    end
  end

  // Debounce and repeat next-state logic; counters clear at their terminal value
  always_comb begin
    w_state_nxt = r_state;
    w_dcnt_nxt  = r_dcnt;
    w_rcnt_nxt  = r_rcnt;
    w_phase_nxt = r_phase;
    w_level_nxt = r_level;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    w_pulse_nxt = 1'b0;
    case (r_state)
      S_RELEASED: begin
        if (w_s) begin
          w_state_nxt = S_WAIT_PRESS;
          w_dcnt_nxt  = CNT_ONE;
        end
      end
      S_WAIT_PRESS: begin
        if (!w_s) begin
          w_state_nxt = S_RELEASED;
          w_dcnt_nxt  = '0;
        end else if (r_dcnt == DEB_LAST) begin
          w_state_nxt = S_PRESSED;
          w_dcnt_nxt  = '0;
          w_level_nxt = 1'b1;
          w_rise_nxt  = 1'b1;
          w_pulse_nxt = 1'b1;
          w_rcnt_nxt  = '0;
          w_phase_nxt = PH_DELAY;
        end else begin
          w_dcnt_nxt = r_dcnt + CNT_ONE;
        end
      end
      S_PRESSED: begin
        if (!w_s) begin
          w_state_nxt = S_WAIT_RELEASE;
          w_dcnt_nxt  = CNT_ONE;
        end else if (REPEAT_EN != 0) begin
          if (r_rcnt == w_rlast) begin
            w_pulse_nxt = 1'b1;
            w_rcnt_nxt  = '0;
            w_phase_nxt = PH_PERIOD;
          end else begin
            w_rcnt_nxt = r_rcnt + CNT_ONE;
          end
        end
      end
      S_WAIT_RELEASE: begin
        // A glitch back to 1 resumes PRESSED with a fresh repeat interval
        if (w_s) begin
          w_state_nxt = S_PRESSED;
          w_dcnt_nxt  = '0;
          w_rcnt_nxt  = '0;
        end else if (r_dcnt == DEB_LAST) begin
          w_state_nxt = S_RELEASED;
          w_dcnt_nxt  = '0;
          w_level_nxt = 1'b0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_dcnt_nxt = r_dcnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = S_RELEASED;
        w_dcnt_nxt  = '0;
      end
    endcase
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;
  assign o_pulse = r_pulse;

endmodule
